// File: rtl/instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage
//
// Registered decode stage between fetch and register-read. Each accepted
// instruction is split into its fields, the immediate is extended and the
// instruction is classified before being stored. The stored result is then
// presented on a valid/ready output. A two-entry skid buffer (MAIN + SKID)
// lets the stage sustain one instruction per cycle while in_ready stays
// purely registered. flush drops every held instruction. decode_cnt counts
// the bundles that downstream has taken.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               discard every held instruction
//   in_valid/in_ready   upstream handshake
//   in_instr            instruction word
//   out_valid/out_ready downstream handshake
//   opcode .. address   decoded fields of the MAIN entry
//   imm_ext             zero- or sign-extended immediate
//   is_rtype/is_jump/is_itype  one-hot instruction class
//   decode_cnt          wrapping count of transferred bundles
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | MAIN invalid, nothing presented
// ONE   | MAIN valid and presented, SKID invalid
// TWO   | MAIN and SKID valid, upstream stalled
// -----------------------------------------------------------------------------
module instruction_decode_stage #(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5,
  parameter int SHAMT_W  = 5,
  parameter int IMM_W    = 16,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  localparam int FUNCT_W = INSTR_W - OPCODE_W - 3*REG_W - SHAMT_W,
  localparam int ADDR_W  = INSTR_W - OPCODE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   imm_ext,
  output logic                is_rtype,
  output logic                is_jump,
  output logic                is_itype,
  output logic [CNT_W-1:0]    decode_cnt
);

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   imm_ext;
    logic                is_rtype;
    logic                is_jump;
    logic                is_itype;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Full decode of one instruction word. Every field is extracted whatever
  // the class, so downstream can pick what it needs without muxing here.
  function automatic bundle_t decode(input logic [INSTR_W-1:0] instr);
    bundle_t             b;
    logic [IMM_W-1:0]    imm;
    logic                zero_ext;
    logic                fill;
    b           = '0;
    b.opcode    = instr[INSTR_W-1 -: OPCODE_W];
    b.rs        = instr[INSTR_W-OPCODE_W-1 -: REG_W];
    b.rt        = instr[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
    b.rd        = instr[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
    b.shamt     = instr[FUNCT_W+SHAMT_W-1 -: SHAMT_W];
    b.funct     = instr[FUNCT_W-1:0];
    b.address   = instr[ADDR_W-1:0];
    imm         = instr[IMM_W-1:0];
    // ANDI/ORI/XORI treat the immediate as a bit mask, so it is zero-extended.
    zero_ext    = (b.opcode == OPCODE_W'(12)) ||
                  (b.opcode == OPCODE_W'(13)) ||
                  (b.opcode == OPCODE_W'(14));
    fill        = imm[IMM_W-1] & ~zero_ext;
    b.imm_ext   = DATA_W'(imm);
    // No iterations when DATA_W == IMM_W: the raw immediate passes through.
    for (int i = IMM_W; i < DATA_W; i++) begin
      b.imm_ext[i] = fill;
    end
    b.is_rtype  = (b.opcode == '0);
    b.is_jump   = (b.opcode == OPCODE_W'(2)) || (b.opcode == OPCODE_W'(3));
    b.is_itype  = ~(b.is_rtype | b.is_jump);
    return b;
  endfunction

  state_t     state_q, state_d;
  bundle_t    main_q, skid_q, in_dec;
  logic [CNT_W-1:0] cnt_q;

  logic accept, xfer;
  logic load_main_in, load_main_skid, load_skid;

  assign in_dec    = decode(in_instr);

  // Both handshake outputs decode the state register only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Held words are dropped by invalidating them. The field registers keep
      // their contents, and any word offered this cycle is ignored.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (xfer) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_dec;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_dec;
      end
    end
  end

  // A transfer in the same cycle as a flush still counts: downstream took it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign opcode     = main_q.opcode;
  assign rs         = main_q.rs;
  assign rt         = main_q.rt;
  assign rd         = main_q.rd;
  assign shamt      = main_q.shamt;
  assign funct      = main_q.funct;
  assign address    = main_q.address;
  assign imm_ext    = main_q.imm_ext;
  assign is_rtype   = main_q.is_rtype;
  assign is_jump    = main_q.is_jump;
  assign is_itype   = main_q.is_itype;
  assign decode_cnt = cnt_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [25:0] address;
  logic [31:0] imm_ext;
  logic        is_rtype, is_jump, is_itype;
  logic [CNT_W-1:0] decode_cnt;

  instruction_decode_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .address(address), .imm_ext(imm_ext),
    .is_rtype(is_rtype), .is_jump(is_jump), .is_itype(is_itype),
    .decode_cnt(decode_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [25:0] addr;
    logic [31:0] imm;
    logic        r, j, i;
  } exp_t;

  exp_t dut_b;
  assign dut_b = {opcode, rs, rt, rd, shamt, funct, address, imm_ext,
                  is_rtype, is_jump, is_itype};

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  // Reference decode written from the field layout with shifts and masks.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int unsigned u, imm;
    u       = w;
    e.op    = 6'((u >> 26) & 63);
    e.rs    = 5'((u >> 21) & 31);
    e.rt    = 5'((u >> 16) & 31);
    e.rd    = 5'((u >> 11) & 31);
    e.shamt = 5'((u >> 6) & 31);
    e.funct = 6'(u & 63);
    e.addr  = 26'(u & 32'h03FF_FFFF);
    imm     = u & 32'hFFFF;
    if (e.op == 12 || e.op == 13 || e.op == 14) e.imm = imm;
    else if (imm >= 32768)                      e.imm = imm - 65536;
    else                                        e.imm = imm;
    e.r = (e.op == 0);
    e.j = (e.op == 2 || e.op == 3);
    e.i = !(e.r || e.j);
    return e;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom % 8)
      0: op = 6'd0;
      1: op = 6'd2;
      2: op = 6'd3;
      3: op = 6'd8;
      4: op = 6'd12;
      5: op = 6'd13;
      6: op = 6'd14;
      default: op = 6'($urandom);
    endcase
    return {op, 26'($urandom)};
  endfunction

  // Monitor / scoreboard: the model occupancy is the queue length.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exp_cnt = 0;
      end else begin
        bit rdy_m;
        rdy_m = (q.size() < 2);
        check("out_valid", 128'(out_valid), 128'(q.size() > 0));
        check("in_ready", 128'(in_ready), 128'(rdy_m));
        check("decode_cnt", 128'(decode_cnt), 128'(exp_cnt));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_bundle", 128'(dut_b), 128'(0));
          end else begin
            exp_t e;
            e = q.pop_front();
            check("bundle", 128'(dut_b), 128'(e));
          end
          exp_cnt = (exp_cnt + 1) % 16;
        end
        if (flush) q.delete();
        else if (in_valid && rdy_m) q.push_back(model(in_instr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    logic rdy;
    in_valid = 1'b1;
    in_instr = w;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    int cnt_snap;
    // Reset state
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_cnt", 128'(decode_cnt), 128'(0));
    check("rst_fields", 128'(dut_b), 128'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Test 1: R-type, back-to-back
    out_ready = 1'b1;
    send(32'h012A4020);
    check("t1_opcode", 128'(opcode), 128'(0));
    check("t1_rs", 128'(rs), 128'(9));
    check("t1_rt", 128'(rt), 128'(10));
    check("t1_rd", 128'(rd), 128'(8));
    check("t1_shamt", 128'(shamt), 128'(0));
    check("t1_funct", 128'(funct), 128'(32'h20));
    check("t1_flags", 128'({is_rtype, is_jump, is_itype}), 128'(3'b100));

    // Test 2: immediates
    send(32'h2128FFFC);
    check("t2_opcode", 128'(opcode), 128'(8));
    check("t2_rs_rt", 128'({rs, rt}), 128'({5'd9, 5'd8}));
    check("t2_imm_sext", 128'(imm_ext), 128'(32'hFFFFFFFC));
    check("t2_flags", 128'({is_rtype, is_jump, is_itype}), 128'(3'b001));
    send(32'h3528FFFC);
    check("t2_imm_zext", 128'(imm_ext), 128'(32'h0000FFFC));

    // Test 3: jump
    send(32'h08000010);
    check("t3_opcode", 128'(opcode), 128'(2));
    check("t3_address", 128'(address), 128'(26'h0000010));
    check("t3_flags", 128'({is_rtype, is_jump, is_itype}), 128'(3'b010));
    repeat (3) tick();

    // Test 4: back-pressure A, B, C
    out_ready = 1'b0;
    send(32'h00A51820);
    send(32'h2042FFFF);
    check("t4_stall_after_b", 128'(in_ready), 128'(0));
    in_valid = 1'b1;
    in_instr = 32'h0C000123;
    repeat (3) tick();
    check("t4_c_held_off", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    send(32'h0C000123);
    repeat (4) tick();

    // Test 5: flush in TWO with a word offered
    out_ready = 1'b0;
    send(32'h11223344);
    send(32'h55667788);
    cnt_snap = exp_cnt;
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hDEADBEEF;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_out_valid", 128'(out_valid), 128'(0));
    check("t5_in_ready", 128'(in_ready), 128'(1));
    check("t5_cnt", 128'(decode_cnt), 128'(cnt_snap));
    out_ready = 1'b1;
    repeat (3) tick();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 25) == 0;
      in_valid  = ($urandom % 3) != 0;
      in_instr  = rand_instr();
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Test 6: async reset mid-stream, then counter wrap
    out_ready = 1'b0;
    send(32'hFFFFFFFF);
    send(32'h012A4020);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 128'(out_valid), 128'(0));
    check("t6_rst_in_ready", 128'(in_ready), 128'(1));
    check("t6_rst_cnt", 128'(decode_cnt), 128'(0));
    check("t6_rst_fields", 128'(dut_b), 128'(0));
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int n = 0; n < 17; n++) send(rand_instr());
    repeat (3) tick();
    check("t6_wrap_cnt", 128'(decode_cnt), 128'(1));
    check("drain_empty", 128'(q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
